// File: rtl/bht_update_ctrl_pkg.sv
// Shared types and constants for the BHT update controller slice.
//   VLEN            : virtual PC width carried with each update
//   BHT_GHR_BITS    : global history length
//   bht_upd_entry_t : one queued resolved-branch update {vpc, taken, ghr}
//   bht_ctrl_state_e: controller FSM state
package bht_update_ctrl_pkg;

  localparam int VLEN         = 64;
  localparam int BHT_GHR_BITS = 4;

  typedef struct packed {
    logic [VLEN-1:0]         vpc;
    logic                    taken;
    logic [BHT_GHR_BITS-1:0] ghr;
  } bht_upd_entry_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } bht_ctrl_state_e;

endpackage

// File: rtl/bht_update_ctrl_if.sv
// Resolved-branch channel from the branch unit into the BHT update controller.
//   valid      : branch unit offers a resolved conditional branch
//   ready      : controller accepts it (valid && ready)
//   pc         : PC of the resolved branch
//   taken      : actual direction
//   mispredict : the prediction was wrong
//   ghr        : GHR checkpoint captured at prediction time
// master = branch unit, slave = controller.
interface bht_update_ctrl_if
  import bht_update_ctrl_pkg::*;
#(
  parameter int GHR_BITS = BHT_GHR_BITS
) ();

  logic                valid;
  logic                ready;
  logic [VLEN-1:0]     pc;
  logic                taken;
  logic                mispredict;
  logic [GHR_BITS-1:0] ghr;

  modport master (
    output valid, pc, taken, mispredict, ghr,
    input  ready
  );

  modport slave (
    input  valid, pc, taken, mispredict, ghr,
    output ready
  );

endinterface

// File: rtl/bht_upd_fifo.sv
// Pending-update FIFO: DEPTH x bht_upd_entry_t circular buffer.
//   clk_i, rst_i : clock, async active-high reset
//   flush_i      : empties the FIFO (pointers and count to zero)
//   push_i       : write data_i at the tail (caller guarantees !full_o)
//   pop_i        : advance the head (caller guarantees !empty_o)
//   data_i       : entry to push
//   data_o       : entry at the head
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module bht_upd_fifo
  import bht_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  bht_upd_entry_t data_i,
  output bht_upd_entry_t data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  bht_upd_entry_t   mem [DEPTH];

  assign full_o  = (count == (PTR_W+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign data_o  = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers are exactly PTR_W bits, so wrap at DEPTH is free (DEPTH is a power of two).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT update controller: owns the speculative GHR, queues resolved-branch
// updates and sequences all writes into the gshare table, including a
// row-per-cycle clear after reset or flush.
//   clk_i, rst_i          : clock, async active-high reset
//   flush_i               : drop queued updates, zero GHR, restart clear
//   debug_mode_i          : accept and discard incoming updates
//   spec_valid_i/taken_i  : frontend prediction shifted into the GHR
//   res                   : resolved-branch channel (slave side)
//   ghr_o                 : speculative GHR for prediction indexing
//   upd_valid_o/pc/taken/ghr : one-cycle table update strobe and fields
//   clr_valid_o/clr_row_o : row being cleared (valid=0, counter=2'b10)
//   busy_o                : high while clearing
//
// state    | meaning
// ST_CLEAR | clearing row clr_row_o, updates only queue
// ST_IDLE  | draining the FIFO onto upd_*_o, one entry per cycle
module bht_update_ctrl
  import bht_update_ctrl_pkg::*;
#(
  parameter int NR_ROWS    = 512,
  parameter int GHR_BITS   = BHT_GHR_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_BITS   = $clog2(NR_ROWS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                debug_mode_i,
  input  logic                spec_valid_i,
  input  logic                spec_taken_i,
  bht_update_ctrl_if.slave    res,
  output logic [GHR_BITS-1:0] ghr_o,
  output logic                upd_valid_o,
  output logic [VLEN-1:0]     upd_pc_o,
  output logic                upd_taken_o,
  output logic [GHR_BITS-1:0] upd_ghr_o,
  output logic                clr_valid_o,
  output logic [ROW_BITS-1:0] clr_row_o,
  output logic                busy_o
);

  bht_ctrl_state_e state;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic           res_acc;
  logic           res_store;
  logic           bypass;
  bht_upd_entry_t res_entry;
  bht_upd_entry_t fifo_head;

  // Debug mode keeps the branch unit flowing while updates are thrown away.
  assign res.ready = debug_mode_i | ~fifo_full;
  assign res_acc   = res.valid & res.ready;
  assign res_store = res_acc & ~debug_mode_i & ~flush_i;

  assign res_entry = '{vpc: res.pc, taken: res.taken, ghr: res.ghr};

  // An update arriving into an empty FIFO while idle goes straight to the
  // output register so it appears the very next cycle.
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty & ~flush_i;
  assign bypass    = (state == ST_IDLE) & fifo_empty & res_store;
  assign fifo_push = res_store & ~bypass;

  bht_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (res_entry),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_CLEAR;
      clr_row_o   <= '0;
      clr_valid_o <= 1'b1;
      busy_o      <= 1'b1;
      upd_valid_o <= 1'b0;
      upd_pc_o    <= '0;
      upd_taken_o <= 1'b0;
      upd_ghr_o   <= '0;
      ghr_o       <= '0;
    end else begin
      upd_valid_o <= 1'b0;
      if (flush_i) begin
        state       <= ST_CLEAR;
        clr_row_o   <= '0;
        clr_valid_o <= 1'b1;
        busy_o      <= 1'b1;
        ghr_o       <= '0;
      end else begin
        // Repair from the checkpoint wins over a same-cycle speculative shift.
        if (res_acc && res.mispredict) begin
          ghr_o <= {res.ghr[GHR_BITS-2:0], res.taken};
        end else if (spec_valid_i) begin
          ghr_o <= {ghr_o[GHR_BITS-2:0], spec_taken_i};
        end

        case (state)
          ST_CLEAR: begin
            clr_row_o <= clr_row_o + 1'b1;
            if (clr_row_o == ROW_BITS'(NR_ROWS - 1)) begin
              state       <= ST_IDLE;
              clr_valid_o <= 1'b0;
              busy_o      <= 1'b0;
            end
          end
          ST_IDLE: begin
            if (fifo_pop) begin
              upd_valid_o <= 1'b1;
              upd_pc_o    <= fifo_head.vpc;
              upd_taken_o <= fifo_head.taken;
              upd_ghr_o   <= fifo_head.ghr;
            end else if (bypass) begin
              upd_valid_o <= 1'b1;
              upd_pc_o    <= res_entry.vpc;
              upd_taken_o <= res_entry.taken;
              upd_ghr_o   <= res_entry.ghr;
            end
          end
          default: state <= ST_CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Randomized bench for bht_update_ctrl with a transaction-level reference model.
module tb_bht_update_ctrl;

  localparam int NR_ROWS  = 512;
  localparam int GHR_BITS = 4;
  localparam int DEPTH    = 4;
  localparam int ROW_BITS = 9;

  typedef struct {
    logic [63:0] pc;
    bit          taken;
    logic [3:0]  ghr;
  } ent_t;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                flush_i = 1'b0;
  logic                debug_mode_i = 1'b0;
  logic                spec_valid_i = 1'b0;
  logic                spec_taken_i = 1'b0;
  logic [GHR_BITS-1:0] ghr_o;
  logic                upd_valid_o;
  logic [63:0]         upd_pc_o;
  logic                upd_taken_o;
  logic [GHR_BITS-1:0] upd_ghr_o;
  logic                clr_valid_o;
  logic [ROW_BITS-1:0] clr_row_o;
  logic                busy_o;

  bht_update_ctrl_if #(.GHR_BITS(GHR_BITS)) res_if ();

  bht_update_ctrl #(
    .NR_ROWS    (NR_ROWS),
    .GHR_BITS   (GHR_BITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .debug_mode_i (debug_mode_i),
    .spec_valid_i (spec_valid_i),
    .spec_taken_i (spec_taken_i),
    .res          (res_if.slave),
    .ghr_o        (ghr_o),
    .upd_valid_o  (upd_valid_o),
    .upd_pc_o     (upd_pc_o),
    .upd_taken_o  (upd_taken_o),
    .upd_ghr_o    (upd_ghr_o),
    .clr_valid_o  (clr_valid_o),
    .clr_row_o    (clr_row_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int n_upd    = 0;

  // reference model state
  bit   m_clearing;
  int   m_row;
  int   m_ghr;
  bit   m_uv;
  ent_t m_upd;
  ent_t q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_clearing = 1'b1;
    m_row      = 0;
    m_ghr      = 0;
    m_uv       = 1'b0;
    q.delete();
  endtask

  task automatic set_res(input bit v, input logic [63:0] pc, input bit tk, input bit mp, input logic [3:0] g);
    res_if.valid      = v;
    res_if.pc         = pc;
    res_if.taken      = tk;
    res_if.mispredict = mp;
    res_if.ghr        = g;
  endtask

  function automatic bit exp_ready();
    return debug_mode_i || (q.size() < DEPTH);
  endfunction

  // One clock: advance the model with the inputs present at the edge, then
  // compare every output #1 later.
  task automatic step();
    bit   rdy;
    bit   acc;
    ent_t e;
    rdy = exp_ready();
    @(posedge clk_i);
    acc  = res_if.valid && rdy;
    m_uv = 1'b0;
    if (flush_i) begin
      q.delete();
      m_ghr      = 0;
      m_clearing = 1'b1;
      m_row      = 0;
    end else begin
      if (acc && res_if.mispredict)
        m_ghr = ((int'(res_if.ghr) << 1) | int'(res_if.taken)) & 15;
      else if (spec_valid_i)
        m_ghr = ((m_ghr << 1) | int'(spec_taken_i)) & 15;
      if (acc && !debug_mode_i) begin
        e.pc = res_if.pc; e.taken = res_if.taken; e.ghr = res_if.ghr;
        q.push_back(e);
      end
      if (!m_clearing && q.size() > 0) begin
        m_upd = q.pop_front();
        m_uv  = 1'b1;
      end
      if (m_clearing) begin
        if (m_row == NR_ROWS - 1) begin
          m_clearing = 1'b0;
          m_row      = 0;
        end else begin
          m_row++;
        end
      end
    end
    #1;
    if (upd_valid_o === 1'b1) n_upd++;
    check("busy", 64'(busy_o), 64'(m_clearing));
    check("clr_valid", 64'(clr_valid_o), 64'(m_clearing));
    if (m_clearing) check("clr_row", 64'(clr_row_o), 64'(m_row));
    check("ghr", 64'(ghr_o), 64'(m_ghr));
    check("upd_valid", 64'(upd_valid_o), 64'(m_uv));
    if (m_uv) begin
      check("upd_pc", upd_pc_o, m_upd.pc);
      check("upd_taken", 64'(upd_taken_o), 64'(m_upd.taken));
      check("upd_ghr", 64'(upd_ghr_o), 64'(m_upd.ghr));
    end
    check("res_ready", 64'(res_if.ready), 64'(exp_ready()));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    check({tag, "_clr_valid"}, 64'(clr_valid_o), 64'd1);
    check({tag, "_clr_row"}, 64'(clr_row_o), 64'd0);
    check({tag, "_upd_valid"}, 64'(upd_valid_o), 64'd0);
    check({tag, "_ghr"}, 64'(ghr_o), 64'd0);
    check({tag, "_ready"}, 64'(res_if.ready), 64'd1);
  endtask

  task automatic run_to_idle(input string tag);
    int guard;
    guard = 0;
    while (busy_o === 1'b1 && guard < 700) begin
      step();
      guard++;
    end
    check({tag, "_clear_done"}, 64'(guard < 700), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pcs [5];
    int busy_cnt;
    int guard;
    int upd_before;

    set_res(1'b0, 64'h0, 1'b0, 1'b0, 4'h0);
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_vals("reset");
    rst_i = 1'b0;

    // Clear length from reset, with 5 pushes into the 4-deep FIFO meanwhile.
    busy_cnt = (busy_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      pcs[i] = {32'h0, $urandom};
      set_res(1'b1, pcs[i], 1'(i), 1'b0, 4'(i + 3));
      check("clear_push_ready", 64'(res_if.ready), (i < 4) ? 64'd1 : 64'd0);
      step();
      if (busy_o === 1'b1) busy_cnt++;
    end
    set_res(1'b0, 64'h0, 1'b0, 1'b0, 4'h0);
    guard = 0;
    while (busy_o === 1'b1 && guard < 700) begin
      step();
      if (busy_o === 1'b1) busy_cnt++;
      guard++;
    end
    check("busy_cycles", 64'(busy_cnt), 64'd512);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_valid", 64'(upd_valid_o), 64'd1);
      check("drain_pc", upd_pc_o, pcs[i]);
    end
    step();
    check("drain_done", 64'(upd_valid_o), 64'd0);

    // Single update from idle appears the next cycle.
    set_res(1'b1, 64'h80, 1'b1, 1'b0, 4'b0101);
    step();
    set_res(1'b0, 64'h0, 1'b0, 1'b0, 4'h0);
    check("idle_upd_valid", 64'(upd_valid_o), 64'd1);
    check("idle_upd_pc", upd_pc_o, 64'h80);
    check("idle_upd_taken", 64'(upd_taken_o), 64'd1);
    check("idle_upd_ghr", 64'(upd_ghr_o), 64'b0101);
    step();

    // GHR repair beats a same-cycle speculative shift.
    spec_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spec_taken_i = (i >= 2);
      step();
    end
    check("ghr_0011", 64'(ghr_o), 64'b0011);
    spec_taken_i = 1'b1;
    set_res(1'b1, 64'h1234, 1'b0, 1'b1, 4'b1000);
    step();
    check("ghr_repair", 64'(ghr_o), 64'b0000);
    spec_valid_i = 1'b0;
    set_res(1'b0, 64'h0, 1'b0, 1'b0, 4'h0);
    step();

    // Flush mid-clear with two queued entries.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 2; i++) begin
      set_res(1'b1, 64'hA000 + 64'(i), 1'b1, 1'b0, 4'h9);
      step();
    end
    set_res(1'b0, 64'h0, 1'b0, 1'b0, 4'h0);
    guard = 0;
    while (m_row != 200 && guard < 600) begin
      step();
      guard++;
    end
    check("reach_row200", 64'(clr_row_o), 64'd200);
    upd_before = n_upd;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_row0", 64'(clr_row_o), 64'd0);
    check("flush_busy", 64'(busy_o), 64'd1);
    run_to_idle("flush");
    repeat (4) step();
    check("flush_no_upd", 64'(n_upd - upd_before), 64'd0);

    // Debug mode: accept and discard.
    debug_mode_i = 1'b1;
    upd_before = n_upd;
    for (int i = 0; i < 3; i++) begin
      set_res(1'b1, 64'hD00 + 64'(i), 1'b0, 1'b0, 4'h2);
      check("debug_ready", 64'(res_if.ready), 64'd1);
      step();
    end
    set_res(1'b0, 64'h0, 1'b0, 1'b0, 4'h0);
    debug_mode_i = 1'b0;
    repeat (4) step();
    check("debug_no_upd", 64'(n_upd - upd_before), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      flush_i      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 63) == 0) debug_mode_i = ~debug_mode_i;
      spec_valid_i = $urandom_range(0, 1);
      spec_taken_i = $urandom_range(0, 1);
      set_res(1'($urandom_range(0, 99) < 60), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      step();
    end
    flush_i = 1'b0;
    debug_mode_i = 1'b0;
    spec_valid_i = 1'b0;

    // Async reset mid-clear with entries queued.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_res(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 4'h7);
      step();
    end
    set_res(1'b0, 64'h0, 1'b0, 1'b0, 4'h0);
    repeat (20) step();
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_reset_vals("async_reset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_reset_vals("post_reset");
    run_to_idle("final");
    repeat (3) step();
    check("final_no_upd", 64'(upd_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
